// File: rtl/booth_mac_pkg.sv
// rtl/booth_mac_pkg.sv - shared state type and default parameters for booth_mac_ctrl
package booth_mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    CAP,
    OUT
  } mac_state_t;

  localparam int ACC_W_DEF      = 24;
  localparam int MUL_CYCLES_DEF = 8;

endpackage

// File: rtl/booth_mac_acc.sv
// rtl/booth_mac_acc.sv - signed product accumulator; BOOTH_MAC_SAT_EN selects sticky saturation over wrap
module booth_mac_acc
  import booth_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add_en,
  input  logic             clear,
  input  logic [15:0]      prod,
  output logic [ACC_W-1:0] sum
);

  logic [ACC_W-1:0] prod_ext;

  assign prod_ext = ACC_W'($signed(prod));

`ifdef BOOTH_MAC_SAT_EN
  localparam logic [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] ext_sum;
  logic           sat;

  // One guard bit: overflow iff the two top bits of the widened sum disagree.
  assign ext_sum = {sum[ACC_W-1], sum} + {prod_ext[ACC_W-1], prod_ext};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      sat <= 1'b0;
    end else if (clear) begin
      sum <= '0;
      sat <= 1'b0;
    end else if (add_en && !sat) begin
      if (ext_sum[ACC_W] != ext_sum[ACC_W-1]) begin
        sat <= 1'b1;
        sum <= ext_sum[ACC_W] ? SUM_MIN : SUM_MAX;
      end else begin
        sum <= ext_sum[ACC_W-1:0];
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + prod_ext;
    end
  end
`endif

endmodule

// File: rtl/booth_mac_ctrl.sv
// rtl/booth_mac_ctrl.sv - sequencer/accumulator around the radix-2 Booth core; BOOTH_MAC_SAT_EN enables saturation
module booth_mac_ctrl
  import booth_mac_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             mul_start,
  output logic [7:0]       mul_multiplicand,
  output logic [7:0]       mul_multiplier,
  input  logic             mul_busy,
  input  logic [15:0]      mul_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_n,
  output logic             err
);

  localparam logic [3:0] WAIT_LOAD = 4'(MUL_CYCLES);

  mac_state_t state, next_state;
  logic [3:0] wait_cnt;
  logic       last_reg;
  logic       acc_add;
  logic       acc_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // in_ready is gated by rst_n so it reads 0 while reset is held.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    mul_start  = 1'b0;
    out_valid  = 1'b0;
    acc_add    = 1'b0;
    acc_clr    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) next_state = LOAD;
      end
      LOAD: begin
        mul_start  = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (wait_cnt == 4'd1) next_state = CAP;
      end
      CAP: begin
        acc_add    = 1'b1;
        next_state = last_reg ? OUT : IDLE;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_clr    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The core's busy re-asserts after its count wraps, so time the run here and sample busy only in CAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      last_reg         <= 1'b0;
      wait_cnt         <= '0;
      out_n            <= '0;
      err              <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        mul_multiplicand <= in_a;
        mul_multiplier   <= in_b;
        last_reg         <= in_last;
      end
      if (state == LOAD)      wait_cnt <= WAIT_LOAD;
      else if (state == WAIT) wait_cnt <= wait_cnt - 4'd1;
      if (acc_add && out_n != 8'hFF) out_n <= out_n + 8'd1;
      else if (acc_clr)              out_n <= '0;
      if (acc_add && mul_busy) err <= 1'b1;
    end
  end

  booth_mac_acc #(
    .ACC_W(ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .add_en (acc_add),
    .clear  (acc_clr),
    .prod   (mul_prod),
    .sum    (out_acc)
  );

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// tb/tb_booth_mac_ctrl.sv - scoreboard bench for booth_mac_ctrl with a behavioural Booth core model
module tb_booth_mac_ctrl;

  localparam int ACC_W = 24;
  localparam longint SUM_MAX = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint SUM_MIN = -(64'sd1 <<< (ACC_W - 1));

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic             in_last = 1'b0;
  logic             mul_start;
  logic [7:0]       mul_multiplicand;
  logic [7:0]       mul_multiplier;
  logic             mul_busy;
  logic [15:0]      mul_prod;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_acc;
  logic [7:0]       out_n;
  logic             err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cyc = -1;
  int prev_hs = -1;

  typedef struct {
    longint acc;
    int     n;
  } exp_t;
  exp_t sb[$];

  longint model_acc = 0;
  int     model_n = 0;
  bit     model_sat = 1'b0;

  logic        force_busy = 1'b0;
  logic [3:0]  core_cnt = 4'd0;
  logic [15:0] core_p = 16'd0;

  booth_mac_ctrl #(.ACC_W(ACC_W), .MUL_CYCLES(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .in_last          (in_last),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_busy         (mul_busy),
    .mul_prod         (mul_prod),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_acc          (out_acc),
    .out_n            (out_n),
    .err              (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: count 0..8 after start, product valid only at 8, then wraps and busy re-asserts.
  always @(posedge clk) begin
    if (mul_start) begin
      core_cnt <= 4'd0;
      core_p   <= $signed(mul_multiplicand) * $signed(mul_multiplier);
    end else if (core_cnt == 4'd8) begin
      core_cnt <= 4'd0;
    end else begin
      core_cnt <= core_cnt + 4'd1;
    end
  end

  assign mul_busy = (core_cnt != 4'd8) | force_busy;
  assign mul_prod = (core_cnt == 4'd8) ? core_p : 16'h5A5A;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_clear();
    model_acc = 0;
    model_n   = 0;
    model_sat = 1'b0;
  endtask

  task automatic model_add(input int a, input int b);
    longint s;
    logic [ACC_W-1:0] t;
    s = model_acc + longint'(a * b);
`ifdef BOOTH_MAC_SAT_EN
    if (!model_sat) begin
      if (s > SUM_MAX) begin
        model_acc = SUM_MAX;
        model_sat = 1'b1;
      end else if (s < SUM_MIN) begin
        model_acc = SUM_MIN;
        model_sat = 1'b1;
      end else begin
        model_acc = s;
      end
    end
`else
    t = s[ACC_W-1:0];
    model_acc = longint'($signed(t));
`endif
    if (model_n < 255) model_n++;
  endtask

  task automatic send_pair(input int a, input int b, input bit last, input bit chk_gap);
    exp_t e;
    int   k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    if (chk_gap && prev_hs >= 0) chk("in_ready_gap", cyc - prev_hs, 11);
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_last  = last;
    in_valid = 1'b1;
    hs_cyc   = cyc;
    prev_hs  = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    in_last  = 1'($urandom);
    model_add(a, b);
    if (last) begin
      e.acc = model_acc;
      e.n   = model_n;
      sb.push_back(e);
      model_clear();
    end
  endtask

  task automatic wait_out(input int hold);
    exp_t e;
    int   k;
    longint held_acc;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    chk("out_latency", cyc - hs_cyc, 11);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("out_acc", $signed(out_acc), 32'(e.acc));
    chk("out_n", 32'(out_n), e.n);
    held_acc = longint'($signed(out_acc));
    for (int i = 0; i < hold; i++) begin
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_acc", $signed(out_acc), 32'(e.acc));
      chk("bp_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_in_ready", 32'(in_ready), 1);
    chk("post_out_valid", 32'(out_valid), 0);
    chk("post_acc_clr", $signed(out_acc), 0);
    chk("post_n_clr", 32'(out_n), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_mul_start"}, 32'(mul_start), 0);
    chk({tag, "_mcand"}, 32'(mul_multiplicand), 0);
    chk({tag, "_mplier"}, 32'(mul_multiplier), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_acc"}, $signed(out_acc), 0);
    chk({tag, "_out_n"}, 32'(out_n), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", 32'(in_ready), 1);

    send_pair(3, 5, 1'b1, 1'b0);
    @(negedge clk);
    chk("load_mul_start", 32'(mul_start), 1);
    chk("load_mcand", 32'(mul_multiplicand), 3);
    chk("load_mplier", 32'(mul_multiplier), 5);
    @(negedge clk);
    chk("wait_mul_start", 32'(mul_start), 0);
    wait_out(0);
    chk("single_err", 32'(err), 0);

    send_pair(-128, -128, 1'b1, 1'b0);
    wait_out(0);
    send_pair(-7, 9, 1'b1, 1'b0);
    wait_out(0);

    prev_hs = -1;
    send_pair(2, 3, 1'b0, 1'b1);
    send_pair(-4, 5, 1'b0, 1'b1);
    send_pair(10, 10, 1'b0, 1'b1);
    send_pair(1, -1, 1'b1, 1'b1);
    wait_out(0);

    send_pair(-100, 50, 1'b0, 1'b0);
    send_pair(17, -3, 1'b1, 1'b0);
    wait_out(20);

    for (int i = 0; i < 600; i++) send_pair(127, 127, i == 599, 1'b0);
    wait_out(0);

    force_busy = 1'b1;
    send_pair(2, 2, 1'b1, 1'b0);
    wait_out(0);
    force_busy = 1'b0;
    chk("err_set", 32'(err), 1);
    send_pair(4, 4, 1'b1, 1'b0);
    wait_out(0);
    chk("err_sticky", 32'(err), 1);

    send_pair(5, 6, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    sb.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_in_ready", 32'(in_ready), 1);
    send_pair(3, 5, 1'b1, 1'b0);
    wait_out(0);
    chk("midrst_err_clear", 32'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
